if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_pkg.sv | 13 +
 rtl/fetch_queue.sv | 58 +++++
 rtl/if_prefetch.sv | 77 +++++++
 3 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction prefetcher.
//   IF_XLEN          - width of the fields held in each queue entry
//   RESET_PC_DEFAULT - default fetch address after reset
//   fetch_entry_t    - one queue slot: fetch PC, returned instruction, filled flag
package if_pkg;
    localparam int IF_XLEN = 32;
    localparam logic [IF_XLEN-1:0] RESET_PC_DEFAULT = 32'h0;
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] inst;
        logic               filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of reserved/filled fetch entries.
//   clk_i, rst_i   - clock, synchronous active-high reset
//   flush_i        - drop every entry (redirect)
//   reserve_i      - allocate tail entry for reserve_pc_i
//   fill_i         - write fill_data_i into the oldest unfilled entry
//   pop_i          - retire the head entry
//   head_o         - head entry contents
//   level_o        - reserved + filled entries
import if_pkg::*;
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         reserve_i,
    input  logic [XLEN-1:0]              reserve_pc_i,
    input  logic                         fill_i,
    input  logic [XLEN-1:0]              fill_data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   tail_ptr, fill_ptr, head_ptr;
    logic [LW-1:0]   count;
    // Reserve, fill and pop never target the same slot: reserve needs a free
    // slot, fill targets an unfilled one and pop a filled one.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            tail_ptr <= '0;
            fill_ptr <= '0;
            head_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
        end else begin
            if (reserve_i) begin
                mem[tail_ptr] <= '{pc: IF_XLEN'(reserve_pc_i), inst: '0, filled: 1'b0};
                tail_ptr      <= tail_ptr + PW'(1);
            end
            if (fill_i) begin
                mem[fill_ptr].inst   <= IF_XLEN'(fill_data_i);
                mem[fill_ptr].filled <= 1'b1;
                fill_ptr             <= fill_ptr + PW'(1);
            end
            if (pop_i) begin
                mem[head_ptr].filled <= 1'b0;
                head_ptr             <= head_ptr + PW'(1);
            end
            count <= count + LW'(reserve_i) - LW'(pop_i);
        end
    end
    assign head_o  = mem[head_ptr];
    assign level_o = count;
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch unit with request credits and redirect discard.
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   redirect_i, redirect_pc_i    - flush queue and restart fetch at redirect_pc_i
//   imem_req_o, imem_addr_o      - fetch request and word-aligned address
//   imem_gnt_i                   - request accepted this cycle
//   imem_rvalid_i, imem_rdata_i  - in-order response
//   inst_valid_o, inst_ready_i   - head handshake to decode
//   inst_o, pc_o, pc4_o          - head instruction, PC and PC+4
//   level_o                      - occupied queue entries
import if_pkg::*;
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         redirect_i,
    input  logic [XLEN-1:0]              redirect_pc_i,
    output logic                         imem_req_o,
    output logic [XLEN-1:0]              imem_addr_o,
    input  logic                         imem_gnt_i,
    input  logic                         imem_rvalid_i,
    input  logic [XLEN-1:0]              imem_rdata_i,
    output logic                         inst_valid_o,
    input  logic                         inst_ready_i,
    output logic [XLEN-1:0]              inst_o,
    output logic [XLEN-1:0]              pc_o,
    output logic [XLEN-1:0]              pc4_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUT+1);
    logic [XLEN-1:0] fetch_pc;
    // outstanding counts every request in flight, including ones being discarded
    logic [OW-1:0]   outstanding, discard_cnt;
    logic            accept, rsp, fill, pop;
    fetch_entry_t    head;
    assign imem_req_o   = !rst_i && !redirect_i && level_o < LW'(DEPTH) && outstanding < OW'(MAX_OUT);
    assign imem_addr_o  = fetch_pc;
    assign accept       = imem_req_o && imem_gnt_i;
    assign rsp          = imem_rvalid_i && outstanding != '0;
    assign fill         = rsp && discard_cnt == '0;
    assign inst_valid_o = head.filled && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = XLEN'(head.inst);
    assign pc_o         = XLEN'(head.pc);
    assign pc4_o        = pc_o + XLEN'(4);
    // On redirect everything still in flight after this cycle becomes stale,
    // which already includes any remaining discard backlog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            fetch_pc    <= redirect_i ? (redirect_pc_i & ~XLEN'(3)) : accept ? fetch_pc + XLEN'(4) : fetch_pc;
            outstanding <= outstanding + OW'(accept) - OW'(rsp);
            discard_cnt <= redirect_i ? outstanding - OW'(rsp) : (rsp && discard_cnt != '0) ? discard_cnt - OW'(1) : discard_cnt;
        end
    end
    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .reserve_i    (accept),
        .reserve_pc_i (fetch_pc),
        .fill_i       (fill),
        .fill_data_i  (imem_rdata_i),
        .pop_i        (pop),
        .head_o       (head),
        .level_o      (level_o)
    );
    // A response with nothing in flight is a memory-side protocol error.
    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) imem_rvalid_i |-> outstanding != '0);
endmodule
